// File: rtl/div_sgn.sv
// -----------------------------------------------------------------------------
// div_sgn
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock. Each operation is signed (two's complement) or unsigned,
// selected when it is started. Divide-by-zero and the common overflow case are
// caught up front and finish in a single clock. Results are held until the
// next accepted start.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active low
//   i_start      start request, sampled only while o_busy = 0
//   i_sgn        1 = signed operands, 0 = unsigned (latched with start)
//   i_num        2N-bit dividend (latched with start)
//   i_denom      N-bit divisor (latched with start)
//   o_quotient   N-bit quotient, held until the next accepted start
//   o_remainder  N-bit remainder, held until the next accepted start
//   o_busy       operation in progress; start is ignored while high
//   o_rdy        results valid, from completion until the next accepted start
//   o_overflow   quotient not representable in N bits for the selected mode
//   o_dbz        divisor was zero
//
// State  | meaning
// -------+--------------------------------------------------------------------
// IDLE   | waiting for start, no result yet
// CALC   | N shift/subtract iterations on the operand magnitudes
// FIX    | apply signs, signed range check, publish results
// DONE   | results valid; accepts start. With busy still set it is the one
//        | clock that publishes a precheck (dbz/overflow) outcome
// -----------------------------------------------------------------------------
module div_sgn #(
    parameter int N = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_sgn,
    input  logic [2*N-1:0] i_num,
    input  logic [N-1:0]   i_denom,
    output logic [N-1:0]   o_quotient,
    output logic [N-1:0]   o_remainder,
    output logic           o_busy,
    output logic           o_rdy,
    output logic           o_overflow,
    output logic           o_dbz
);

    localparam int              CW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]    HALF     = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_rem;       // partial remainder
    logic [N-1:0]   r_dvd;       // dividend bits not yet shifted in
    logic [N-1:0]   r_dvs;       // divisor magnitude
    logic [N-1:0]   r_quo;       // quotient magnitude being built
    logic           r_sgn;
    logic           r_sign_q;
    logic           r_sign_r;
    logic [N-1:0]   r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_busy;
    logic           r_rdy;
    logic           r_overflow;
    logic           r_dbz;

    logic [2*N-1:0] w_num_mag;
    logic [N-1:0]   w_den_mag;
    logic           w_dbz;
    logic           w_pre_ovf;
    logic [N:0]     w_shift;
    logic           w_ge;
    logic [N-1:0]   w_rem_next;
    logic           w_fix_ovf;

    // Operand magnitudes; the most negative value maps onto its correct
    // unsigned magnitude because the magnitude is treated as unsigned.
    assign w_num_mag = (i_sgn && i_num[2*N-1])  ? -i_num   : i_num;
    assign w_den_mag = (i_sgn && i_denom[N-1])  ? -i_denom : i_denom;

    assign w_dbz     = (w_den_mag == '0);
    // Upper half >= divisor means the quotient magnitude needs more than N bits.
    assign w_pre_ovf = !w_dbz && (w_num_mag[2*N-1:N] >= w_den_mag);

    // One restoring step. The shifted value is N+1 bits wide; when it is not
    // below the divisor the difference is below the divisor, so N bits hold it.
    assign w_shift    = {r_rem, r_dvd[N-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[N-1:0] - r_dvs) : w_shift[N-1:0];

    // Signed range: a positive result may reach 2^(N-1)-1, a negative 2^(N-1).
    assign w_fix_ovf = r_sgn && (r_sign_q ? (r_quo > HALF) : (r_quo >= HALF));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_sgn       <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b0;
            r_overflow  <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE && r_busy) begin
                        // Publish a precheck outcome one clock after accept.
                        r_busy      <= 1'b0;
                        r_rdy       <= 1'b1;
                        r_quotient  <= '0;
                        r_remainder <= '0;
                    end else if (i_start) begin
                        r_sgn      <= i_sgn;
                        r_sign_q   <= i_sgn & (i_num[2*N-1] ^ i_denom[N-1]);
                        r_sign_r   <= i_sgn & i_num[2*N-1];
                        r_dvs      <= w_den_mag;
                        r_rem      <= w_num_mag[2*N-1:N];
                        r_dvd      <= w_num_mag[N-1:0];
                        r_quo      <= '0;
                        r_cnt      <= CNT_LAST;
                        r_busy     <= 1'b1;
                        r_rdy      <= 1'b0;
                        r_dbz      <= w_dbz;
                        r_overflow <= w_pre_ovf;
                        r_state    <= (w_dbz || w_pre_ovf) ? S_DONE : S_CALC;
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_quo <= {r_quo[N-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= S_DONE;
                    if (w_fix_ovf) begin
                        r_overflow  <= 1'b1;
                        r_quotient  <= '0;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= r_sign_q ? -r_quo : r_quo;
                        r_remainder <= r_sign_r ? -r_rem : r_rem;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_busy      = r_busy;
    assign o_rdy       = r_rdy;
    assign o_overflow  = r_overflow;
    assign o_dbz       = r_dbz;

endmodule

// File: tb/tb_div_sgn.sv
module tb_div_sgn;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] num;
    logic [7:0]  denom;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        rdy;
    logic        overflow;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    div_sgn #(.N(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_sgn       (sgn),
        .i_num       (num),
        .i_denom     (denom),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_busy      (busy),
        .o_rdy       (rdy),
        .o_overflow  (overflow),
        .o_dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division on the operands' numeric values.
    function automatic void model(input bit s, input logic [15:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit ov, output bit dz, output int lat);
        longint nn, dd, an, ad, qq, rr;
        if (s) begin
            nn = longint'($signed(n));
            dd = longint'($signed(d));
        end else begin
            nn = longint'(n);
            dd = longint'(d);
        end
        q = '0; r = '0; ov = 0; dz = 0;
        if (dd == 0) begin
            dz = 1; lat = 1;
            return;
        end
        an = (nn < 0) ? -nn : nn;
        ad = (dd < 0) ? -dd : dd;
        if (an / ad >= 256) begin
            ov = 1; lat = 1;
            return;
        end
        lat = 9;
        qq = nn / dd;
        rr = nn % dd;
        ov = s ? (qq < -128 || qq > 127) : (qq > 255);
        if (!ov) begin
            q = qq[7:0];
            r = rr[7:0];
        end
    endfunction

    task automatic run_op(input bit s, input logic [15:0] n, input logic [7:0] d, input string tag);
        logic [7:0] eq, er;
        bit eov, edz;
        int elat, cyc;
        model(s, n, d, eq, er, eov, edz, elat);
        @(negedge clk);
        sgn = s; num = n; denom = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num = 16'($urandom); denom = 8'($urandom); sgn = 1'($urandom);
        chk({tag, ".busy_acc"}, busy, 1);
        chk({tag, ".rdy_drop"}, rdy, 0);
        cyc = 0;
        while (!rdy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, cyc, elat);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".ovf"}, overflow, eov);
        chk({tag, ".dbz"}, dbz, edz);
        chk({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b0; start = 1'b0; sgn = 1'b0; num = '0; denom = '0;
        #23;
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.busy", busy, 0);
        chk("rst.rdy", rdy, 0);
        chk("rst.ovf", overflow, 0);
        chk("rst.dbz", dbz, 0);
        @(negedge clk); rst = 1'b1;

        // Directed cases
        run_op(0, 16'd1000, 8'd7,    "u1000_7");
        run_op(0, 16'h0A00, 8'h0A,   "u_pre_ovf");
        run_op(0, 16'h1234, 8'h00,   "u_dbz");
        run_op(1, 16'hFF9C, 8'd7,    "s_m100_7");
        run_op(1, 16'd100,  8'hF9,   "s_100_m7");
        run_op(1, 16'hFC00, 8'd8,    "s_m1024_8");
        run_op(1, 16'd1024, 8'd8,    "s_1024_8_fixovf");
        run_op(1, 16'h8000, 8'h80,   "s_min_min");
        run_op(1, 16'hFFFF, 8'h00,   "s_dbz");
        run_op(0, 16'h00FF, 8'hFF,   "u_ff_ff");

        // Reset during the fourth CALC cycle
        @(negedge clk);
        sgn = 1'b0; num = 16'd1000; denom = 8'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst.q", quotient, 0);
        chk("midrst.r", remainder, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.rdy", rdy, 0);
        chk("midrst.ovf", overflow, 0);
        chk("midrst.dbz", dbz, 0);
        @(negedge clk); rst = 1'b1;
        run_op(0, 16'd1000, 8'd7, "after_rst");

        // Start pulsed while busy is ignored
        @(negedge clk);
        sgn = 1'b0; num = 16'd1000; denom = 8'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        sgn = 1'b1; num = 16'hFF9C; denom = 8'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1;
        while (!rdy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ign.latency", cyc, 9);
        chk("ign.q", quotient, 8'd142);
        chk("ign.r", remainder, 8'd6);

        // Start in DONE: rdy drops, old results stay visible while busy
        @(negedge clk);
        sgn = 1'b1; num = 16'hFF9C; denom = 8'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("redo.rdy", rdy, 0);
        chk("redo.busy", busy, 1);
        chk("redo.held_q", quotient, 8'd142);
        chk("redo.held_r", remainder, 8'd6);
        cyc = 0;
        while (!rdy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("redo.latency", cyc, 9);
        chk("redo.q", quotient, 8'hF2);
        chk("redo.r", remainder, 8'hFE);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [15:0] rn;
            logic [7:0]  rd;
            int mode;
            rn = 16'($urandom);
            rd = 8'($urandom);
            mode = int'($urandom_range(0, 4));
            if (mode == 1 || mode == 2) rn = rn >> $urandom_range(4, 12);
            if (mode == 3) rd = 8'h00;
            if (mode == 2 && rn[15]) rn = -rn;
            run_op(1'($urandom), rn, rd, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
